div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU) in the EX stage. It takes ALU operands and the 5-bit ALU opcode from the ID/EX register and runs a 32-iteration restoring division. While it runs, it holds the pipeline with STALL and returns a registered 32-bit result with a one-cycle DONE pulse. MUL-family and all other ALUOP values bypass this block and stay in the single-cycle ALU.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- START  input  1  request; qualified by ALUOP being a divide opcode.
- ALUOP  input  5  01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU; any other value makes START ignored.
- DATA1  input  XLEN  dividend (rs1).
- DATA2  input  XLEN  divisor (rs2).
- FLUSH  input  1  abort the in-flight operation (branch/jump squash).
- STALL  output  1  pipeline hold request.
- DONE  output  1  one-cycle result-valid pulse.
- RESULT  output  XLEN  quotient or remainder, held until the next DONE.

## Operation
- States:
  - IDLE: no operation in flight.
  - RUN: iterating; a 6-bit counter runs 0..31.
  - DONE: result valid for one cycle.
- IDLE→RUN on accepted START:
  - Latch the opcode.
  - Latch the sign flags (signed ops only): sign of dividend, and sign of dividend XOR sign of divisor.
  - Latch the magnitudes of the operands.
  - Clear the partial remainder; set counter to 0.
- RUN, each edge, one restoring step:
  - Shift {rem, quo} left by one.
  - Trial subtraction rem − divisor, computed XLEN+1 bits wide.
  - If the trial result is non-negative, keep the difference and set quo[0]=1.
  - Counter increments.
- RUN→DONE on the edge where the counter is 31. That same edge registers RESULT:
  - Quotient is negated if the XOR sign flag is set.
  - Remainder is negated if the dividend sign flag is set.
  - REM/REMU select the remainder; DIV/DIVU select the quotient.
- DONE→IDLE next edge, or DONE→RUN if a new valid START is present (back-to-back).
- Forced results override the datapath output, and are always applied:
  - Divisor = 0: quotient = all ones; remainder = DATA1.
  - DIV/REM with DATA1 = 0x8000_0000 and DATA2 = 0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- STALL = (state==RUN) | (state!=RUN & valid START). STALL is low in the DONE cycle so EX/MEM captures RESULT.
- FLUSH (any state):
  - Next state is IDLE; no DONE is produced.
  - FLUSH takes priority over START in the same cycle.
  - RESULT keeps its previous value.
- Reset values: state IDLE, STALL 0, DONE 0, RESULT 0, counter 0, all internal registers 0.
- A reset asserted mid-RUN abandons the operation immediately (asynchronous).

## Timing
- START accepted at edge k → iterations on edges k+1..k+32 → DONE=1 and RESULT valid in the cycle after edge k+32. Latency is 33 cycles.
- STALL rises combinationally in the cycle START is presented and stays high through the last RUN cycle.
- DONE is never high for two consecutive cycles except with back-to-back STARTs, which still see 33 cycles between DONE pulses.
- Operand inputs are sampled only on the accepting edge; later changes have no effect.

## Configuration
- DIV_SEQ_EARLY_OUT_EN defined:
  - Divide-by-zero and the signed-overflow case go IDLE→DONE at edge k+1 with the forced result. Latency is 1; STALL is high for one cycle only.
  - Divisor magnitude greater than dividend magnitude also finishes at edge k+1: quotient 0, remainder DATA1.
- Undefined: every operation takes 33 cycles. RESULT values are bit-identical in both builds.

## Structure
- Shared package `rv32_pkg`:
  - ALUOP divide codes (DIV=5'b01100 … REMU=5'b01111).
  - div_state_t enum (IDLE, RUN, DONE).
  - XLEN constant.
- Sub-module `div_step`: combinational single restoring step (rem_in, quo_in, divisor → rem_out, quo_out). Instantiated once in RUN.
- The FSM, sign handling and forced-result logic stay in div_sequencer.

## Test plan
- DIVU 100/7 at edge k: STALL high 33 cycles; DONE in cycle after k+32; RESULT=14. Repeat as REMU: RESULT=2.
- DIV −100/7 → 0xFFFF_FFF2 (−14); REM −100/7 → 0xFFFF_FFFE (−2); DIV 100/−7 → −14.
- DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5; DIV 0x8000_0000/−1 → 0x8000_0000; REM → 0. With DIV_SEQ_EARLY_OUT_EN, DONE follows at k+1.
- FLUSH asserted on the 10th RUN cycle → IDLE next edge; STALL low; no DONE; RESULT unchanged from the prior operation.
- Back-to-back: second DIVU 0xFFFF_FFFF/3 START held during DONE of the first → accepted; second DONE exactly 33 cycles later; RESULT=0x5555_5555.
- RESETN pulled low mid-RUN → STALL, DONE and RESULT read 0 immediately; after release a fresh DIVU 9/3 returns 3.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension divide opcodes, divider FSM states, XLEN.
// Used by the multi-cycle divide sequencer in EX.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALUOP_DIV  = 5'b01100;
    localparam logic [4:0] ALUOP_DIVU = 5'b01101;
    localparam logic [4:0] ALUOP_REM  = 5'b01110;
    localparam logic [4:0] ALUOP_REMU = 5'b01111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // The four divide opcodes share the 011xx prefix; bit0 = unsigned, bit1 = remainder.
    function automatic logic is_div_op(input logic [4:0] op);
        return op[4:2] == 3'b011;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem, quo} with an XLEN+1-bit trial subtract.
// Zero latency; no handshake.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[XLEN]) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring divide, 33-cycle latency, STALL holds the pipe.
// DIV_SEQ_EARLY_OUT_EN finishes divide-by-zero, signed overflow and |divisor|>|dividend| in one cycle.
module div_sequencer #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    import rv32_pkg::*;

    localparam logic [1:0] ST_IDLE = DIV_IDLE;
    localparam logic [1:0] ST_RUN  = DIV_RUN;
    localparam logic [1:0] ST_DONE = DIV_DONE;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            rem_op_q, rem_op_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            start_vld, signed_op, d1_neg, d2_neg, in_dz, in_ovf;
    logic [XLEN-1:0] d1_mag, d2_mag;
    logic [XLEN-1:0] step_rem, step_quo, fin_quo, fin_rem;

    assign start_vld = START & is_div_op(ALUOP);
    assign signed_op = ~ALUOP[0];
    assign d1_neg    = signed_op & DATA1[XLEN-1];
    assign d2_neg    = signed_op & DATA2[XLEN-1];
    assign d1_mag    = d1_neg ? -DATA1 : DATA1;
    assign d2_mag    = d2_neg ? -DATA2 : DATA2;
    assign in_dz     = (DATA2 == '0);
    assign in_ovf    = signed_op & (DATA1 == MIN_NEG) & (DATA2 == '1);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Divide-by-zero remainder falls out of the datapath as DATA1 once sign-restored.
    assign fin_quo = dz_q  ? '1 :
                     ovf_q ? MIN_NEG :
                     (neg_quo_q ? -step_quo : step_quo);
    assign fin_rem = ovf_q ? '0 : (neg_rem_q ? -step_rem : step_rem);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_op_d  = rem_op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;

        if (state_q == ST_RUN) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                state_d  = ST_DONE;
                cnt_d    = '0;
                result_d = rem_op_q ? fin_rem : fin_quo;
            end
        end else begin
            state_d = ST_IDLE;
            if (start_vld) begin
                state_d   = ST_RUN;
                cnt_d     = '0;
                rem_op_d  = ALUOP[1];
                neg_quo_d = d1_neg ^ d2_neg;
                neg_rem_d = d1_neg;
                dz_d      = in_dz;
                ovf_d     = in_ovf;
                rem_d     = '0;
                quo_d     = d1_mag;
                div_d     = d2_mag;
`ifdef DIV_SEQ_EARLY_OUT_EN
                if (in_dz) begin
                    state_d  = ST_DONE;
                    result_d = ALUOP[1] ? DATA1 : '1;
                end else if (in_ovf) begin
                    state_d  = ST_DONE;
                    result_d = ALUOP[1] ? '0 : MIN_NEG;
                end else if (d2_mag > d1_mag) begin
                    state_d  = ST_DONE;
                    result_d = ALUOP[1] ? DATA1 : '0;
                end
`endif
            end
        end

        if (FLUSH) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_op_q  <= rem_op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
        end
    end

    assign STALL  = (state_q == ST_RUN) | ((state_q != ST_RUN) & start_vld);
    assign DONE   = (state_q == ST_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: signed/unsigned results, forced cases, flush, back-to-back, reset.
module tb_div_sequencer;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        START = 1'b0;
    logic [4:0]  ALUOP = 5'b0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        FLUSH = 1'b0;
    logic        STALL, DONE;
    logic [31:0] RESULT;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REM  = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;

    div_sequencer #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .ALUOP  (ALUOP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .STALL  (STALL),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op, check STALL over the whole run and the result in the DONE cycle.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        logic ok;
        @(posedge CLK); #1;
        START = 1'b1; ALUOP = op; DATA1 = a; DATA2 = b;
        @(negedge CLK);
        chk({tag, "_stall_start"}, {31'b0, STALL}, 32'd1);
        @(posedge CLK); #1;
        START = 1'b0; DATA1 = $urandom; DATA2 = $urandom;
        ok = 1'b1;
        repeat (32) begin
            @(negedge CLK);
            if (!STALL || DONE) ok = 1'b0;
        end
        chk({tag, "_run_window"}, {31'b0, ok}, 32'd1);
        @(negedge CLK);
        chk({tag, "_done"}, {31'b0, DONE}, 32'd1);
        chk({tag, "_stall_low"}, {31'b0, STALL}, 32'd0);
        chk({tag, "_result"}, RESULT, exp);
        @(negedge CLK);
        chk({tag, "_done_drop"}, {31'b0, DONE}, 32'd0);
    endtask

    initial begin
        logic ok;
        logic done_seen;

        #2;
        chk("rst_stall", {31'b0, STALL}, 32'd0);
        chk("rst_done", {31'b0, DONE}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        @(posedge CLK); #1;
        RESETN = 1'b1;

        // MUL-family opcode must not start the divider.
        @(posedge CLK); #1;
        START = 1'b1; ALUOP = 5'b01000; DATA1 = 32'd6; DATA2 = 32'd2;
        @(negedge CLK);
        chk("mul_no_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        chk("mul_idle", {31'b0, STALL | DONE}, 32'd0);

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        do_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        do_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        do_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        do_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2);
        do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5);
        do_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("divu_prev", OP_DIVU, 32'd100, 32'd7, 32'd14);

        // Flush on the 10th RUN cycle.
        @(posedge CLK); #1;
        START = 1'b1; ALUOP = OP_DIV; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        FLUSH = 1'b1;
        @(negedge CLK);
        chk("flush_cycle_stall", {31'b0, STALL}, 32'd1);
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_stall_low", {31'b0, STALL}, 32'd0);
        chk("flush_result_kept", RESULT, 32'd14);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE || STALL) done_seen = 1'b1;
        end
        chk("flush_no_done", {31'b0, done_seen}, 32'd0);
        chk("flush_result_after", RESULT, 32'd14);

        // Back-to-back: second START held in the DONE cycle of the first.
        @(posedge CLK); #1;
        START = 1'b1; ALUOP = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (32) @(negedge CLK);
        @(negedge CLK);
        chk("b2b_first_done", {31'b0, DONE}, 32'd1);
        chk("b2b_first_result", RESULT, 32'd14);
        START = 1'b1; ALUOP = OP_DIVU; DATA1 = 32'hFFFF_FFFF; DATA2 = 32'd3;
        #1;
        chk("b2b_stall_in_done", {31'b0, STALL}, 32'd1);
        @(posedge CLK); #1;
        START = 1'b0; DATA1 = 32'd0; DATA2 = 32'd0;
        ok = 1'b1;
        repeat (32) begin
            @(negedge CLK);
            if (!STALL || DONE) ok = 1'b0;
        end
        chk("b2b_gap", {31'b0, ok}, 32'd1);
        @(negedge CLK);
        chk("b2b_second_done", {31'b0, DONE}, 32'd1);
        chk("b2b_second_result", RESULT, 32'h5555_5555);

        // Asynchronous reset in the middle of a run.
        @(posedge CLK); #1;
        START = 1'b1; ALUOP = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RESETN = 1'b0;
        #1;
        chk("arst_stall", {31'b0, STALL}, 32'd0);
        chk("arst_done", {31'b0, DONE}, 32'd0);
        chk("arst_result", RESULT, 32'd0);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        @(negedge CLK);
        chk("arst_idle", {31'b0, STALL | DONE}, 32'd0);
        do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
